// File: rtl/iso14443_frame_router_if.sv
// Bundle of the framing-side Rx/Tx signals and the per-client fan-out/fan-in buses of the frame router.
// master = framing layer plus clients, slave = the router.
interface iso14443_frame_router_if #(
    parameter int NUM_CHANNELS = 2,
    parameter int LEN_WIDTH    = 6
);
    localparam int SEL_WIDTH = $clog2(NUM_CHANNELS);

    logic [SEL_WIDTH-1:0]      route_sel;
    logic                      rx_soc;
    logic                      rx_eoc;
    logic [7:0]                rx_data;
    logic                      rx_data_valid;
    logic                      rx_error;
    logic                      rx_crc_ok;

    logic [NUM_CHANNELS-1:0]   out_rx_soc;
    logic [NUM_CHANNELS-1:0]   out_rx_eoc;
    logic [NUM_CHANNELS-1:0]   out_rx_data_valid;
    logic [NUM_CHANNELS-1:0]   out_rx_error;
    logic [7:0]                out_rx_data;
    logic                      out_rx_crc_ok;
    logic [LEN_WIDTH-1:0]      out_rx_len;

    logic [NUM_CHANNELS-1:0]   tx_req;
    logic [8*NUM_CHANNELS-1:0] tx_data;
    logic [NUM_CHANNELS-1:0]   tx_last;
    logic [NUM_CHANNELS-1:0]   tx_append_crc;
    logic [NUM_CHANNELS-1:0]   tx_grant;
    logic [NUM_CHANNELS-1:0]   tx_ack;

    logic                      out_tx_valid;
    logic [7:0]                out_tx_data;
    logic                      out_tx_last;
    logic                      out_tx_append_crc;
    logic                      out_tx_ready;

    modport master (
        output route_sel, rx_soc, rx_eoc, rx_data, rx_data_valid, rx_error, rx_crc_ok,
        output tx_req, tx_data, tx_last, tx_append_crc, out_tx_ready,
        input  out_rx_soc, out_rx_eoc, out_rx_data_valid, out_rx_error,
        input  out_rx_data, out_rx_crc_ok, out_rx_len,
        input  tx_grant, tx_ack, out_tx_valid, out_tx_data, out_tx_last, out_tx_append_crc
    );

    modport slave (
        input  route_sel, rx_soc, rx_eoc, rx_data, rx_data_valid, rx_error, rx_crc_ok,
        input  tx_req, tx_data, tx_last, tx_append_crc, out_tx_ready,
        output out_rx_soc, out_rx_eoc, out_rx_data_valid, out_rx_error,
        output out_rx_data, out_rx_crc_ok, out_rx_len,
        output tx_grant, tx_ack, out_tx_valid, out_tx_data, out_tx_last, out_tx_append_crc
    );
endinterface

// File: rtl/iso14443_frame_router.sv
// Routes 14443-3A Rx frames to client channels and arbitrates client Tx frames onto one framing port.
// Latency: Rx outputs registered, 1 cycle; Tx valid/data/last are a combinational mux of the granted client.
// Backpressure: out_tx_ready stalls the granted client via tx_ack; Rx has none, Tx grants wait for Rx idle.
module iso14443_frame_router #(
    parameter int                      NUM_CHANNELS   = 2,
    parameter logic [NUM_CHANNELS-1:0] ALWAYS_RX_MASK = 'b01,
    parameter int                      LEN_WIDTH      = 6
) (
    input logic                    clk,
    input logic                    rst,
    iso14443_frame_router_if.slave bus
);

    localparam logic [LEN_WIDTH-1:0] LEN_MAX = '1;

    typedef logic [NUM_CHANNELS-1:0] chan_vec_t;
    typedef enum logic {TX_IDLE, TX_GRANT} tx_state_t;

    // ------------------------------------------------------------------
    // Rx steering
    // ------------------------------------------------------------------
    chan_vec_t            sel_onehot;
    chan_vec_t            dest_mask_now;
    chan_vec_t            rx_dest_mask;
    logic                 rx_busy;
    logic                 rx_busy_next;

    chan_vec_t            soc_q;
    chan_vec_t            eoc_q;
    chan_vec_t            dv_q;
    chan_vec_t            err_q;
    logic [7:0]           rx_data_q;
    logic                 crc_ok_q;
    logic [LEN_WIDTH-1:0] len_q;

    // The soc cycle already uses its own destination so the soc strobe reaches the new target.
    always_comb begin
        sel_onehot = '0;
        if (int'(bus.route_sel) < NUM_CHANNELS) begin
            sel_onehot[bus.route_sel] = 1'b1;
        end else begin
            sel_onehot[0] = 1'b1;
        end
        dest_mask_now = bus.rx_soc ? (sel_onehot | ALWAYS_RX_MASK) : rx_dest_mask;
        rx_busy_next  = bus.rx_soc | (rx_busy & ~bus.rx_eoc & ~bus.rx_error);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_dest_mask <= '0;
            rx_busy      <= 1'b0;
            soc_q        <= '0;
            eoc_q        <= '0;
            dv_q         <= '0;
            err_q        <= '0;
            rx_data_q    <= '0;
            crc_ok_q     <= 1'b0;
            len_q        <= '0;
        end else begin
            rx_dest_mask <= dest_mask_now;
            rx_busy      <= rx_busy_next;
            soc_q        <= dest_mask_now & {NUM_CHANNELS{bus.rx_soc}};
            eoc_q        <= dest_mask_now & {NUM_CHANNELS{bus.rx_eoc}};
            dv_q         <= dest_mask_now & {NUM_CHANNELS{bus.rx_data_valid}};
            err_q        <= dest_mask_now & {NUM_CHANNELS{bus.rx_error}};
            crc_ok_q     <= bus.rx_eoc & bus.rx_crc_ok;
            if (bus.rx_data_valid) begin
                rx_data_q <= bus.rx_data;
            end
            // A byte arriving with soc is the first byte of the new frame.
            if (bus.rx_soc) begin
                len_q <= {{(LEN_WIDTH-1){1'b0}}, bus.rx_data_valid};
            end else if (bus.rx_data_valid && (len_q != LEN_MAX)) begin
                len_q <= len_q + 1'b1;
            end
        end
    end

    assign bus.out_rx_soc        = soc_q;
    assign bus.out_rx_eoc        = eoc_q;
    assign bus.out_rx_data_valid = dv_q;
    assign bus.out_rx_error      = err_q;
    assign bus.out_rx_data       = rx_data_q;
    assign bus.out_rx_crc_ok     = crc_ok_q;
    assign bus.out_rx_len        = len_q;

    // ------------------------------------------------------------------
    // Tx arbitration
    // ------------------------------------------------------------------
    tx_state_t  tx_state;
    tx_state_t  tx_state_next;
    chan_vec_t  grant_q;
    chan_vec_t  grant_next;
    chan_vec_t  req_pick;
    logic       crc_q;
    logic       crc_next;
    logic       tx_valid;
    logic       tx_last_mux;
    logic       tx_accept;
    logic [7:0] tx_data_mux;

    always_comb begin
        tx_data_mux = '0;
        tx_last_mux = 1'b0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (grant_q[i]) begin
                tx_data_mux = bus.tx_data[8*i +: 8];
                tx_last_mux = bus.tx_last[i];
            end
        end
        tx_valid  = |(grant_q & bus.tx_req);
        tx_accept = tx_valid & bus.out_tx_ready;
    end

    // Fixed priority: lowest index wins.
    always_comb begin
        req_pick = '0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (bus.tx_req[i]) begin
                req_pick    = '0;
                req_pick[i] = 1'b1;
            end
        end
    end

    always_comb begin
        tx_state_next = tx_state;
        grant_next    = grant_q;
        crc_next      = crc_q;
        case (tx_state)
            TX_IDLE: begin
                if ((|bus.tx_req) && !rx_busy_next) begin
                    tx_state_next = TX_GRANT;
                    grant_next    = req_pick;
                    crc_next      = |(req_pick & bus.tx_append_crc);
                end
            end
            TX_GRANT: begin
                if (tx_accept && tx_last_mux) begin
                    tx_state_next = TX_IDLE;
                    grant_next    = '0;
                    crc_next      = 1'b0;
                end
            end
            default: begin
                tx_state_next = TX_IDLE;
                grant_next    = '0;
                crc_next      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            grant_q  <= '0;
            crc_q    <= 1'b0;
        end else begin
            tx_state <= tx_state_next;
            grant_q  <= grant_next;
            crc_q    <= crc_next;
        end
    end

    assign bus.tx_grant          = grant_q;
    assign bus.tx_ack            = grant_q & {NUM_CHANNELS{tx_accept}};
    assign bus.out_tx_valid      = tx_valid;
    assign bus.out_tx_data       = tx_data_mux;
    assign bus.out_tx_last       = tx_last_mux;
    assign bus.out_tx_append_crc = crc_q;

endmodule
